// File: rtl/cp_insert.sv
`default_nettype none
// ============================================================================
// Module   : cp_insert
// Purpose  : Cyclic-prefix insertion for the OFDM transmit chain. Buffers one
//            IFFT symbol of N samples in a ping-pong RAM, then streams the
//            last CP samples followed by all N samples.
// Revision : 1.0  initial release
// ============================================================================
module cp_insert #(
  parameter int DW   = 32,
  parameter int NMAX = 512,
  parameter int AW   = 9
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [1:0]    STD_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          WE_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          WE_O,
  output logic          STB_O,
  output logic          CYC_O,
  input  logic          ACK_I,
  output logic          ERR_O
);

  // Standard-dependent geometry: index of the last sample (N-1) and the
  // first prefix address (N-CP). Reserved code 11 falls back to 00.
  localparam logic [AW-1:0] c_LAST_64  = AW'(63);
  localparam logic [AW-1:0] c_LAST_256 = AW'(255);
  localparam logic [AW-1:0] c_LAST_512 = AW'(511);
  localparam logic [AW-1:0] c_CPS_64   = AW'(48);
  localparam logic [AW-1:0] c_CPS_256  = AW'(192);
  localparam logic [AW-1:0] c_CPS_512  = AW'(384);

  function automatic logic [AW-1:0] f_last(input logic [1:0] s);
    case (s)
      2'b01:   f_last = c_LAST_256;
      2'b10:   f_last = c_LAST_512;
      default: f_last = c_LAST_64;
    endcase
  endfunction

  function automatic logic [AW-1:0] f_cp_start(input logic [1:0] s);
    case (s)
      2'b01:   f_cp_start = c_CPS_256;
      2'b10:   f_cp_start = c_CPS_512;
      default: f_cp_start = c_CPS_64;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREF = 2'd1,
    ST_CP   = 2'd2,
    ST_BODY = 2'd3
  } state_t;

  // Two banks of NMAX words, bank select is the address MSB.
  logic [DW-1:0]     r_mem [0:2*NMAX-1];

  logic [1:0]        r_full;
  logic [1:0][1:0]   r_bank_std;
  logic              r_wr_bank;
  logic [AW-1:0]     r_wr_cnt;
  logic              r_err;

  state_t            r_state;
  logic              r_rd_bank;
  logic [AW-1:0]     r_rd_addr;
  logic [AW-1:0]     r_rd_last;
  logic [DW-1:0]     r_dat;
  logic              r_vld;

  logic [1:0]        w_wr_std;
  logic              w_wr_last;
  logic              w_wr_xfer;
  logic              w_wr_done;
  logic              w_rd_xfer;
  logic              w_rd_last_word;
  logic              w_rd_done;
  logic              w_rd_adv;
  logic [AW-1:0]     w_rd_raddr;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;

  // The standard of the symbol being written is taken live on its first
  // sample and from the bank's latched copy afterwards.
  assign w_wr_std  = (r_wr_cnt == '0) ? STD_I : r_bank_std[r_wr_bank];
  assign w_wr_last = (r_wr_cnt == f_last(w_wr_std));

  // Accept only into an empty bank; held low while reset is asserted.
  assign ACK_O     = RST_I & CYC_I & ~r_full[r_wr_bank];
  assign w_wr_xfer = CYC_I & STB_I & WE_I & ACK_O;
  assign w_wr_done = w_wr_xfer & w_wr_last;

  assign w_rd_xfer      = r_vld & ACK_I;
  assign w_rd_last_word = (r_rd_addr == r_rd_last);
  assign w_rd_done      = w_rd_xfer & (r_state == ST_BODY) & w_rd_last_word;

  assign w_full_set = {w_wr_done &  r_wr_bank, w_wr_done & ~r_wr_bank};
  assign w_full_clr = {w_rd_done &  r_rd_bank, w_rd_done & ~r_rd_bank};

  // Next read address: the word to be presented after the current one is
  // consumed. The RAM is only read when the output register may advance.
  always_comb begin
    w_rd_adv   = 1'b0;
    w_rd_raddr = r_rd_addr;
    case (r_state)
      ST_PREF: begin
        w_rd_adv   = 1'b1;
        w_rd_raddr = f_cp_start(r_bank_std[r_rd_bank]);
      end
      ST_CP: begin
        if (w_rd_xfer) begin
          w_rd_adv   = 1'b1;
          w_rd_raddr = w_rd_last_word ? '0 : r_rd_addr + AW'(1);
        end
      end
      ST_BODY: begin
        if (w_rd_xfer && !w_rd_last_word) begin
          w_rd_adv   = 1'b1;
          w_rd_raddr = r_rd_addr + AW'(1);
        end
      end
      default: begin
        w_rd_adv   = 1'b0;
        w_rd_raddr = r_rd_addr;
      end
    endcase
  end

  // Sample storage; contents are not reset.
  always_ff @(posedge CLK_I) begin
    if (w_wr_xfer) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= DAT_I;
    end
  end

  // Output data register doubles as the synchronous RAM read port.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_dat <= '0;
    end else if (w_rd_adv) begin
      r_dat <= r_mem[{r_rd_bank, w_rd_raddr}];
    end
  end

  // Write side: sample counter, bank toggle, per-bank standard, abort pulse.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_bank_std <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_wr_xfer) begin
        if (r_wr_cnt == '0) begin
          r_bank_std[r_wr_bank] <= STD_I;
        end
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + AW'(1);
        end
      end else if (!CYC_I && (r_wr_cnt != '0)) begin
        r_wr_cnt <= '0;
        r_err    <= 1'b1;
      end
    end
  end

  // Bank occupancy: set on symbol completion, cleared on read release.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_full <= '0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  // Read FSM: banks are drained strictly in fill order.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state   <= ST_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_addr <= '0;
      r_rd_last <= '0;
      r_vld     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state <= ST_PREF;
          end
        end
        ST_PREF: begin
          r_rd_addr <= w_rd_raddr;
          r_rd_last <= f_last(r_bank_std[r_rd_bank]);
          r_vld     <= 1'b1;
          r_state   <= ST_CP;
        end
        ST_CP: begin
          if (w_rd_xfer) begin
            r_rd_addr <= w_rd_raddr;
            if (w_rd_last_word) begin
              r_state <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (w_rd_xfer) begin
            if (w_rd_last_word) begin
              r_vld     <= 1'b0;
              r_rd_bank <= ~r_rd_bank;
              r_state   <= r_full[~r_rd_bank] ? ST_PREF : ST_IDLE;
            end else begin
              r_rd_addr <= w_rd_raddr;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DAT_O = r_dat;
  assign STB_O = r_vld;
  assign WE_O  = r_vld;
  assign CYC_O = r_vld;
  assign ERR_O = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cp_insert.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp_insert
// Purpose  : Self-checking bench for cp_insert with a queue-based model of
//            the expected prefix+body output stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_cp_insert;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  std_i;
  logic [31:0] dat_i;
  logic        we_i, stb_i, cyc_i, ack_i;
  logic        ack_o, we_o, stb_o, cyc_o, err_o;
  logic [31:0] dat_o;

  cp_insert dut (
    .CLK_I(clk), .RST_I(rst_n), .STD_I(std_i), .DAT_I(dat_i),
    .WE_I(we_i), .STB_I(stb_i), .CYC_I(cyc_i), .ACK_O(ack_o),
    .DAT_O(dat_o), .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o),
    .ACK_I(ack_i), .ERR_O(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor state (written only by the monitor processes).
  int          cyc_no    = 0;
  logic [31:0] got_q[$];
  int          rise_q[$];
  int          cyc_hi    = 0;
  int          err_cnt   = 0;
  int          hold_viol = 0;
  logic        prev_stb  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [31:0] prev_dat  = '0;

  // Reference model state.
  logic [31:0] exp_q[$];
  int          got_base;
  int          last_in_cyc;
  bit          ack_run;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Collect transfers and watch output stability away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb <= 1'b0;
      prev_ack <= 1'b0;
    end else begin
      if (stb_o && ack_i) got_q.push_back(dat_o);
      if (stb_o && !prev_stb) rise_q.push_back(cyc_no);
      if (cyc_o) cyc_hi <= cyc_hi + 1;
      if (err_o) err_cnt <= err_cnt + 1;
      if (prev_stb && !prev_ack && (stb_o !== 1'b1 || dat_o !== prev_dat))
        hold_viol <= hold_viol + 1;
      prev_stb <= stb_o;
      prev_ack <= ack_i;
      prev_dat <= dat_o;
    end
  end

  function automatic int nsym(input logic [1:0] s);
    case (s)
      2'b01:   return 256;
      2'b10:   return 512;
      default: return 64;
    endcase
  endfunction

  // Offer count samples; tag>=0 gives {tag,k}, otherwise random data.
  // A complete symbol is appended to the model as tail CP then all N.
  task automatic send_symbol(input logic [1:0] s, input int count, input int tag);
    int n = nsym(s);
    int cp = n / 4;
    logic [31:0] sym[$];
    logic [31:0] d;
    bit acc;
    int w;
    for (int k = 0; k < count; k++) begin
      d = (tag >= 0) ? {tag[15:0], k[15:0]} : $urandom;
      std_i = s; dat_i = d; stb_i = 1'b1; we_i = 1'b1; cyc_i = 1'b1;
      acc = 1'b0; w = 0;
      while (!acc && w < 6000) begin
        @(negedge clk);
        if (ack_o === 1'b1) begin acc = 1'b1; last_in_cyc = cyc_no; end
        @(posedge clk); #1;
        w++;
      end
      if (!acc) begin
        total++; bad++;
        $display("FAIL ack_timeout sample=%0d accepted=0 want=1", k);
        stb_i = 1'b0; we_i = 1'b0;
        return;
      end
      sym.push_back(d);
    end
    stb_i = 1'b0; we_i = 1'b0;
    if (count == n) begin
      for (int i = n - cp; i < n; i++) exp_q.push_back(sym[i]);
      for (int i = 0; i < n; i++) exp_q.push_back(sym[i]);
    end
  endtask

  // mode 0: always accept; 1: 1,0,0,1 repeating; 2: random.
  task automatic ack_driver(input int mode);
    int i = 0;
    while (ack_run) begin
      case (mode)
        0: ack_i = 1'b1;
        1: ack_i = ((i % 4) == 0) || ((i % 4) == 3);
        default: ack_i = 1'($urandom_range(0, 1));
      endcase
      i++;
      @(posedge clk); #1;
    end
    ack_i = 1'b1;
  endtask

  task automatic wait_out(input int limit);
    int w = 0;
    while ((got_q.size() - got_base) < exp_q.size() && w < limit) begin
      @(posedge clk); w++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    exp_q.delete();
    got_base = got_q.size();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc_i = 1'b1; stb_i = 1'b0; we_i = 1'b0; ack_i = 1'b1;
    std_i = 2'b00; dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", ack_o); end
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b want=0", stb_o); end
    total++; if (we_o  !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", we_o); end
    total++; if (cyc_o !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b want=0", cyc_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_o); end
    total++; if (dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h want=0", dat_o); end
    cyc_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL idle_ack_nocyc got=%b want=0", ack_o); end
  endtask

  task automatic test_single();
    int c0, r0, i0;
    start_test();
    c0 = cyc_hi; r0 = rise_q.size();
    ack_run = 1'b1;
    fork
      ack_driver(0);
      begin
        send_symbol(2'b00, 64, 0);
        i0 = last_in_cyc + 1;
        cyc_i = 1'b0;
        wait_out(500);
        ack_run = 1'b0;
      end
    join
    total++;
    if ((got_q.size() - got_base) != 80) begin bad++; $display("FAIL single_count got=%0d want=80", got_q.size() - got_base); end
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      total++;
      if (got_q[got_base + i] !== exp_q[i]) begin bad++; $display("FAIL single_data idx=%0d got=%h want=%h", i, got_q[got_base + i], exp_q[i]); end
    end
    total++; if ((cyc_hi - c0) != 80) begin bad++; $display("FAIL single_cyc_len got=%0d want=80", cyc_hi - c0); end
    total++;
    if (rise_q.size() <= r0) begin bad++; $display("FAIL single_latency got=none want=2"); end
    else if ((rise_q[r0] - i0) != 2) begin bad++; $display("FAIL single_latency got=%0d want=2", rise_q[r0] - i0); end
  endtask

  task automatic test_back_to_back();
    int r0;
    start_test();
    r0 = rise_q.size();
    ack_run = 1'b1;
    fork
      ack_driver(0);
      begin
        for (int s = 0; s < 3; s++) send_symbol(2'b01, 256, s);
        cyc_i = 1'b0;
        wait_out(3000);
        ack_run = 1'b0;
      end
    join
    total++;
    if ((got_q.size() - got_base) != 960) begin bad++; $display("FAIL b2b_count got=%0d want=960", got_q.size() - got_base); end
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      total++;
      if (got_q[got_base + i] !== exp_q[i]) begin bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", i, got_q[got_base + i], exp_q[i]); end
    end
    total++;
    if (rise_q.size() < r0 + 3) begin bad++; $display("FAIL b2b_rises got=%0d want=3", rise_q.size() - r0); end
    else begin
      if ((rise_q[r0 + 1] - rise_q[r0]) != 321) begin bad++; $display("FAIL b2b_gap1 got=%0d want=321", rise_q[r0 + 1] - rise_q[r0]); end
      total++;
      if ((rise_q[r0 + 2] - rise_q[r0 + 1]) != 321) begin bad++; $display("FAIL b2b_gap2 got=%0d want=321", rise_q[r0 + 2] - rise_q[r0 + 1]); end
    end
  endtask

  task automatic test_ack_pattern();
    int h0;
    start_test();
    h0 = hold_viol;
    ack_run = 1'b1;
    fork
      ack_driver(1);
      begin
        send_symbol(2'b10, 512, -1);
        cyc_i = 1'b0;
        wait_out(4000);
        ack_run = 1'b0;
      end
    join
    total++;
    if ((got_q.size() - got_base) != 640) begin bad++; $display("FAIL pat_count got=%0d want=640", got_q.size() - got_base); end
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      total++;
      if (got_q[got_base + i] !== exp_q[i]) begin bad++; $display("FAIL pat_data idx=%0d got=%h want=%h", i, got_q[got_base + i], exp_q[i]); end
    end
    total++; if (hold_viol != h0) begin bad++; $display("FAIL pat_hold got=%0d want=0", hold_viol - h0); end
  endtask

  task automatic test_stall();
    int h0;
    start_test();
    h0 = hold_viol;
    ack_run = 1'b1;
    fork
      begin
        ack_i = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        ack_driver(0);
      end
      begin
        send_symbol(2'b00, 64, -1);
        send_symbol(2'b00, 64, -1);
        stb_i = 1'b1; we_i = 1'b1; cyc_i = 1'b1;
        @(negedge clk);
        total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL stall_ack got=%b want=0", ack_o); end
        total++; if ((got_q.size() - got_base) != 0) begin bad++; $display("FAIL stall_noout got=%0d want=0", got_q.size() - got_base); end
        @(posedge clk); #1;
        send_symbol(2'b00, 64, -1);
        cyc_i = 1'b0;
        wait_out(6000);
        ack_run = 1'b0;
      end
    join
    total++;
    if ((got_q.size() - got_base) != 240) begin bad++; $display("FAIL stall_count got=%0d want=240", got_q.size() - got_base); end
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      total++;
      if (got_q[got_base + i] !== exp_q[i]) begin bad++; $display("FAIL stall_data idx=%0d got=%h want=%h", i, got_q[got_base + i], exp_q[i]); end
    end
    total++; if (hold_viol != h0) begin bad++; $display("FAIL stall_hold got=%0d want=0", hold_viol - h0); end
  endtask

  task automatic test_partial();
    int e0;
    start_test();
    e0 = err_cnt;
    send_symbol(2'b00, 30, -1);
    cyc_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if ((err_cnt - e0) != 1) begin bad++; $display("FAIL partial_err got=%0d want=1", err_cnt - e0); end
    total++; if ((got_q.size() - got_base) != 0) begin bad++; $display("FAIL partial_noout got=%0d want=0", got_q.size() - got_base); end
    ack_run = 1'b1;
    fork
      ack_driver(0);
      begin
        send_symbol(2'b00, 64, -1);
        cyc_i = 1'b0;
        wait_out(500);
        ack_run = 1'b0;
      end
    join
    total++;
    if ((got_q.size() - got_base) != 80) begin bad++; $display("FAIL partial_next_count got=%0d want=80", got_q.size() - got_base); end
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      total++;
      if (got_q[got_base + i] !== exp_q[i]) begin bad++; $display("FAIL partial_data idx=%0d got=%h want=%h", i, got_q[got_base + i], exp_q[i]); end
    end
    total++; if ((err_cnt - e0) != 1) begin bad++; $display("FAIL partial_err_once got=%0d want=1", err_cnt - e0); end
  endtask

  task automatic test_random_std();
    int h0;
    logic [1:0] s;
    start_test();
    h0 = hold_viol;
    ack_run = 1'b1;
    fork
      ack_driver(2);
      begin
        for (int j = 0; j < 4; j++) begin
          s = 2'($urandom_range(0, 3));
          send_symbol(s, nsym(s), -1);
          repeat ($urandom_range(0, 20)) @(posedge clk);
          #1;
        end
        cyc_i = 1'b0;
        wait_out(8000);
        ack_run = 1'b0;
      end
    join
    total++;
    if ((got_q.size() - got_base) != exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", got_q.size() - got_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      total++;
      if (got_q[got_base + i] !== exp_q[i]) begin bad++; $display("FAIL rnd_data idx=%0d got=%h want=%h", i, got_q[got_base + i], exp_q[i]); end
    end
    total++; if (hold_viol != h0) begin bad++; $display("FAIL rnd_hold got=%0d want=0", hold_viol - h0); end
  endtask

  task automatic test_reset_mid();
    int w;
    start_test();
    ack_run = 1'b1;
    fork
      ack_driver(0);
      begin
        send_symbol(2'b00, 64, -1);
        w = 0;
        while ((got_q.size() - got_base) < 40 && w < 500) begin @(posedge clk); w++; end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL midrst_stb got=%b want=0", stb_o); end
        total++; if (cyc_o !== 1'b0) begin bad++; $display("FAIL midrst_cyc got=%b want=0", cyc_o); end
        total++; if (we_o  !== 1'b0) begin bad++; $display("FAIL midrst_we got=%b want=0", we_o); end
        total++; if (dat_o !== 32'h0) begin bad++; $display("FAIL midrst_dat got=%h want=0", dat_o); end
        total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b want=0", ack_o); end
        ack_run = 1'b0;
      end
    join
    cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    start_test();
    ack_run = 1'b1;
    fork
      ack_driver(0);
      begin
        send_symbol(2'b00, 64, 7);
        cyc_i = 1'b0;
        wait_out(500);
        ack_run = 1'b0;
      end
    join
    total++;
    if ((got_q.size() - got_base) != 80) begin bad++; $display("FAIL postrst_count got=%0d want=80", got_q.size() - got_base); end
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++) begin
      total++;
      if (got_q[got_base + i] !== exp_q[i]) begin bad++; $display("FAIL postrst_data idx=%0d got=%h want=%h", i, got_q[got_base + i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ack_pattern();
    test_stall();
    test_partial();
    test_random_std();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
